// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding and address-width helper for the multi-port register file.
package reg_file_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reg_file_clear_ctrl.sv
// reg_file_clear_ctrl: sequential clear engine that walks every entry once after reset or a clear request.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = addr_w(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // The counter wraps to 0 on its own when the last entry is cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d   = cnt_q + AW'(1);
            state_d = (cnt_q == AW'(NREGS - 1)) ? RUN : CLEAR;
        end else if (clear_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end
    always_comb begin
        clr_we   = (state_q == CLEAR);
        clr_addr = cnt_q;
        ready    = (state_q == RUN);
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with zero register, write bypass
// and a clear engine sharing the single array write port.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  reg_write,
    input  logic [AW-1:0]         write_reg,
    input  logic [XLEN-1:0]       write_data,
    input  logic                  clear_req,
    output logic                  ready
);
    logic [XLEN-1:0] mem_q [NREGS];
    logic            clr_we, usr_we, we, usr_live;
    logic [AW-1:0]   clr_addr, waddr;
    logic [XLEN-1:0] wdata;

    reg_file_clear_ctrl #(.NREGS(NREGS), .AW(AW)) u_clear (
        .clock    (clock),
        .reset    (reset),
        .clear_req(clear_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // A user write only lands in RUN and loses to a same-cycle clear request.
    assign usr_live = ready & reg_write & ~clear_req;
    assign usr_we   = usr_live & ~((ZERO_REG != 0) && (write_reg == '0));
    assign we       = ~reset & (clr_we | usr_we);
    assign waddr    = clr_we ? clr_addr : write_reg;
    assign wdata    = clr_we ? '0 : write_data;

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[p*AW +: AW];
        assign rd_data[p*XLEN +: XLEN] =
            !ready                                             ? '0         :
            ((ZERO_REG != 0) && (ra == '0))                    ? '0         :
            ((BYPASS != 0) && usr_live && (write_reg == ra))   ? write_data :
                                                                 mem_q[ra];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench; dut_a is 4-port with bypass and zero reg,
// dut_b is 2-port with neither, both sharing the same stimulus.
module tb_reg_file_mp;
    logic         clock = 1'b0, reset = 1'b1, reg_write = 1'b0, clear_req = 1'b0;
    logic [4:0]   write_reg = '0;
    logic [31:0]  write_data = '0;
    logic [19:0]  rd_addr_a = '0;
    logic [9:0]   rd_addr_b;
    logic [127:0] rd_data_a;
    logic [63:0]  rd_data_b;
    logic         ready_a, ready_b;
    int           n_tests = 0, n_fail = 0;

    assign rd_addr_b = rd_addr_a[9:0];
    always #5 clock = ~clock;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .clear_req(clear_req), .ready(ready_a)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .clear_req(clear_req), .ready(ready_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int p);
        return rd_data_a[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rb(input int p);
        return rd_data_b[p*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        rd_addr_a = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        reg_write  = 1'b1;
        write_reg  = r;
        write_data = d;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            #4;
            check({tag, "_ready_a_low"}, 32'(ready_a), 32'd0);
            check({tag, "_ready_b_low"}, 32'(ready_b), 32'd0);
            check({tag, "_rd_a0_zero"}, ra(0), 32'd0);
            check({tag, "_rd_b1_zero"}, rb(1), 32'd0);
            step();
        end
        #4;
        check({tag, "_ready_a_high"}, 32'(ready_a), 32'd1);
        check({tag, "_ready_b_high"}, 32'(ready_b), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            set_addr(5'(i), 5'(i), 5'(i), 5'(i));
            #1;
            check({tag, "_a"}, ra(3), 32'd0);
            check({tag, "_b"}, rb(0), 32'd0);
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        set_addr(5, 9, 0, 31);
        wait_clear("init");
        check_zero("init_mem");

        // Same-cycle write: bypassed on dut_a, visible one cycle later on dut_b.
        step();
        set_addr(5, 5, 5, 5);
        wr(5, 32'hDEADBEEF);
        #4;
        check("byp_a_same", ra(0), 32'hDEADBEEF);
        check("nobyp_b_same", rb(0), 32'd0);
        step();
        reg_write = 1'b0;
        #4;
        check("byp_a_next", ra(0), 32'hDEADBEEF);
        check("nobyp_b_next", rb(0), 32'hDEADBEEF);

        // Writes to entry 0 are dropped only where the zero register is enabled.
        step();
        set_addr(0, 0, 0, 0);
        wr(0, 32'h1234);
        #4;
        check("zero_a0_same", ra(0), 32'd0);
        check("zero_a1_same", ra(1), 32'd0);
        check("zero_b0_same", rb(0), 32'd0);
        step();
        reg_write = 1'b0;
        #4;
        check("zero_a0_next", ra(0), 32'd0);
        check("nozero_b0_next", rb(0), 32'h1234);

        for (int r = 1; r <= 3; r++) begin
            step();
            wr(5'(r), 32'(r * 32'h11));
        end
        step();
        wr(7, 32'hA5A5A5A5);
        set_addr(7, 7, 7, 7);
        #4;
        for (int p = 0; p < 4; p++) check("same7_byp", ra(p), 32'hA5A5A5A5);
        check("prev3_b_nobyp", rb(1), 32'd0);
        step();
        reg_write = 1'b0;
        #4;
        for (int p = 0; p < 4; p++) check("same7_arr", ra(p), 32'hA5A5A5A5);
        check("same7_b", rb(1), 32'hA5A5A5A5);
        set_addr(1, 2, 3, 7);
        #1;
        check("mix_r1", ra(0), 32'h11);
        check("mix_r2", ra(1), 32'h22);
        check("mix_r3", ra(2), 32'h33);
        check("mix_r7", ra(3), 32'hA5A5A5A5);

        for (int r = 1; r <= 31; r++) begin
            step();
            wr(5'(r), 32'h100 + 32'(r));
        end
        step();
        reg_write = 1'b0;
        set_addr(9, 31, 1, 0);
        #1;
        check("fill_r9", ra(0), 32'h109);
        check("fill_r31", ra(1), 32'h11F);
        check("fill_b_r31", rb(1), 32'h11F);

        // Clear request beats a same-cycle write, including its bypass.
        step();
        wr(9, 32'hFF);
        clear_req = 1'b1;
        #4;
        check("clrreq_nobyp", ra(0), 32'h109);
        check("clrreq_ready", 32'(ready_a), 32'd1);
        step();
        reg_write = 1'b0;
        clear_req = 1'b0;
        wait_clear("clr");
        check_zero("clr_mem");

        // Reset during a clear restarts the walk from entry 0.
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
